// File: rtl/dca_matrix_row_streamer.sv
// Drains a DCA matrix register onto a valid/ready row stream, one row per beat,
// optionally transposing the matrix first so that columns are streamed instead.
module dca_matrix_row_streamer #(
   parameter  int unsigned MATRIX_SIZE_PARA = 8,
   parameter  int unsigned BW_TENSOR_SCALAR = 32,
   localparam int unsigned BW_TENSOR_ROW    = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR
) (
   input  logic                     clk,
   input  logic                     rstnn,
   input  logic                     start,
   input  logic                     start_transpose,
   input  logic                     clear,
   output logic                     busy,
   output logic                     done,
   output logic                     mreg_transpose,
   output logic                     mreg_shift_up,
   input  logic [BW_TENSOR_ROW-1:0] mreg_upmost_rdata_list1d,
   output logic                     stream_valid,
   input  logic                     stream_ready,
   output logic [BW_TENSOR_ROW-1:0] stream_data,
   output logic                     stream_last
);

   localparam int unsigned CNT_W = $clog2(MATRIX_SIZE_PARA + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_XPOSE  = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                   r_state;
   logic [CNT_W-1:0]         r_rows_issued;
   logic                     r_valid;
   logic                     r_last;
   logic [BW_TENSOR_ROW-1:0] r_data;

   logic w_handshake;
   logic w_load;

   // A row is pulled from the register whenever the output slot is free or being emptied.
   assign w_handshake = r_valid & stream_ready;
   assign w_load      = (r_state == S_STREAM)
                      & (r_rows_issued < CNT_W'(MATRIX_SIZE_PARA))
                      & (~r_valid | stream_ready);

   assign mreg_shift_up  = w_load & ~clear;
   assign mreg_transpose = (r_state == S_XPOSE) & ~clear;
   assign busy           = (r_state != S_IDLE);
   assign done           = (r_state == S_DONE);
   assign stream_valid   = r_valid;
   assign stream_last    = r_last;
   assign stream_data    = r_data;

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         r_state       <= S_IDLE;
         r_rows_issued <= '0;
         r_valid       <= 1'b0;
         r_last        <= 1'b0;
         r_data        <= '0;
      end else if (clear) begin
         r_state       <= S_IDLE;
         r_rows_issued <= '0;
         r_valid       <= 1'b0;
         r_last        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rows_issued <= '0;
                  r_state       <= start_transpose ? S_XPOSE : S_STREAM;
               end
            end
            S_XPOSE: begin
               r_state <= S_STREAM;
            end
            S_STREAM: begin
               if (w_handshake && r_last) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
               end else if (w_load) begin
                  r_data        <= mreg_upmost_rdata_list1d;
                  r_valid       <= 1'b1;
                  r_last        <= (r_rows_issued == CNT_W'(MATRIX_SIZE_PARA - 1));
                  r_rows_issued <= r_rows_issued + CNT_W'(1);
               end else if (w_handshake) begin
                  r_valid <= 1'b0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dca_matrix_row_streamer.sv
// Bench for dca_matrix_row_streamer: behavioural matrix register, stream monitor and
// scenario tasks comparing beats against row/column views of the loaded matrix.
module tb_dca_matrix_row_streamer;

   localparam int unsigned N  = 4;
   localparam int unsigned SW = 8;
   localparam int unsigned RW = N * SW;

   logic          clk = 1'b0;
   logic          rstnn, start, start_transpose, clear;
   logic          busy, done, mreg_transpose, mreg_shift_up;
   logic [RW-1:0] upmost, stream_data;
   logic          stream_valid, stream_ready, stream_last;

   always #5 clk = ~clk;

   dca_matrix_row_streamer #(.MATRIX_SIZE_PARA(N), .BW_TENSOR_SCALAR(SW)) dut (
      .clk                      (clk),
      .rstnn                    (rstnn),
      .start                    (start),
      .start_transpose          (start_transpose),
      .clear                    (clear),
      .busy                     (busy),
      .done                     (done),
      .mreg_transpose           (mreg_transpose),
      .mreg_shift_up            (mreg_shift_up),
      .mreg_upmost_rdata_list1d (upmost),
      .stream_valid             (stream_valid),
      .stream_ready             (stream_ready),
      .stream_data              (stream_data),
      .stream_last              (stream_last)
   );

   // Matrix register model: load, shift-up with zero fill, or element transpose.
   logic [RW-1:0] m      [N];
   logic [RW-1:0] ld_val [N];
   logic          ld_req;

   always @(posedge clk) begin
      if (ld_req) begin
         for (int i = 0; i < N; i++) m[i] <= ld_val[i];
      end else if (mreg_shift_up) begin
         for (int i = 0; i < N - 1; i++) m[i] <= m[i+1];
         m[N-1] <= '0;
      end else if (mreg_transpose) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               m[i][SW*j +: SW] <= m[j][SW*i +: SW];
      end
   end
   assign upmost = m[0];

   // Stream monitor: accepted beats and control pulse counts.
   logic [RW-1:0] got_q [$];
   logic          got_l [$];
   int            n_shift = 0, n_xpose = 0, n_done = 0;

   always @(negedge clk) begin
      if (rstnn) begin
         if (mreg_shift_up)  n_shift++;
         if (mreg_transpose) n_xpose++;
         if (done)           n_done++;
         if (stream_valid && stream_ready && !clear) begin
            got_q.push_back(stream_data);
            got_l.push_back(stream_last);
         end
      end
   end

   int            checks = 0, errors = 0;
   logic [RW-1:0] src [N];

   // Expected beat k: row k, or column k when transposed.
   function automatic logic [RW-1:0] exp_beat(input int k, input bit xp);
      logic [RW-1:0] r;
      if (!xp) return src[k];
      for (int j = 0; j < N; j++) r[SW*j +: SW] = src[j][SW*k +: SW];
      return r;
   endfunction

   task automatic load_matrix(input logic [RW-1:0] v0, v1, v2, v3);
      @(posedge clk); #1;
      ld_val[0] = v0; ld_val[1] = v1; ld_val[2] = v2; ld_val[3] = v3;
      src[0] = v0; src[1] = v1; src[2] = v2; src[3] = v3;
      ld_req = 1'b1;
      @(posedge clk); #1;
      ld_req = 1'b0;
   endtask

   task automatic load_std();
      load_matrix(32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
   endtask

   task automatic do_start(input bit xp);
      @(posedge clk); #1;
      start = 1'b1; start_transpose = xp;
      @(posedge clk); #1;
      start = 1'b0; start_transpose = 1'b0;
   endtask

   task automatic wait_done(input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (rnd) stream_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy, done, stream_valid, stream_last, mreg_shift_up, mreg_transpose} !== 6'b0 || stream_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs got b%b d%b v%b l%b s%b x%b data %h", busy, done, stream_valid,
                  stream_last, mreg_shift_up, mreg_transpose, stream_data);
      end
      @(posedge clk); #1 rstnn = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || stream_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release got busy %b valid %b exp 0 0", busy, stream_valid);
      end
   endtask

   task automatic test_plain();
      int bs, bd, bq;
      load_std();
      stream_ready = 1'b1;
      bs = n_shift; bd = n_done; bq = got_q.size();
      @(posedge clk); #1 start = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL plain_busy_t got %b exp 0", busy); end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checks++;
      if (mreg_shift_up !== 1'b1 || stream_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL plain_t1 got shift %b valid %b busy %b exp 1 0 1", mreg_shift_up, stream_valid, busy);
      end
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         checks++;
         if (stream_valid !== 1'b1 || stream_data !== exp_beat(k, 0) || stream_last !== 1'(k == N - 1)) begin
            errors++;
            $display("FAIL plain_beat%0d got v%b %h l%b exp v1 %h l%b", k, stream_valid, stream_data,
                     stream_last, exp_beat(k, 0), 1'(k == N - 1));
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || stream_valid !== 1'b0) begin
         errors++; $display("FAIL plain_done got done %b valid %b exp 1 0", done, stream_valid);
      end
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL plain_idle got busy %b done %b exp 0 0", busy, done);
      end
      checks++;
      if (n_shift - bs !== 4 || n_done - bd !== 1 || got_q.size() - bq !== 4) begin
         errors++; $display("FAIL plain_counts got shifts %0d dones %0d beats %0d exp 4 1 4",
                            n_shift - bs, n_done - bd, got_q.size() - bq);
      end
      checks++;
      if (m[0] !== '0 || m[1] !== '0 || m[2] !== '0 || m[3] !== '0) begin
         errors++; $display("FAIL plain_mreg_empty got %h %h %h %h exp 0", m[0], m[1], m[2], m[3]);
      end
   endtask

   task automatic test_transpose();
      int bx;
      load_std();
      stream_ready = 1'b1;
      bx = n_xpose;
      do_start(1'b1);
      @(negedge clk);
      checks++;
      if (mreg_transpose !== 1'b1 || mreg_shift_up !== 1'b0) begin
         errors++; $display("FAIL xpose_t1 got xpose %b shift %b exp 1 0", mreg_transpose, mreg_shift_up);
      end
      @(negedge clk);
      checks++;
      if (mreg_shift_up !== 1'b1 || stream_valid !== 1'b0 || mreg_transpose !== 1'b0) begin
         errors++; $display("FAIL xpose_t2 got shift %b valid %b xpose %b exp 1 0 0", mreg_shift_up, stream_valid, mreg_transpose);
      end
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         checks++;
         if (stream_valid !== 1'b1 || stream_data !== exp_beat(k, 1) || stream_last !== 1'(k == N - 1)) begin
            errors++;
            $display("FAIL xpose_beat%0d got v%b %h l%b exp v1 %h l%b", k, stream_valid, stream_data,
                     stream_last, exp_beat(k, 1), 1'(k == N - 1));
         end
      end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b1 || n_xpose - bx !== 1) begin
         errors++; $display("FAIL xpose_done got done %b xposes %0d exp 1 1", done, n_xpose - bx);
      end
   endtask

   task automatic test_backpressure();
      int            bs, bq;
      bit            ok;
      logic [RW-1:0] held_d;
      logic          held_l;
      load_std();
      stream_ready = 1'b0;
      bs = n_shift; bq = got_q.size();
      do_start(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (stream_valid === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_first_valid got timeout exp valid"); end
      held_d = stream_data; held_l = stream_last;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (stream_valid !== 1'b1 || stream_data !== held_d || stream_last !== held_l || mreg_shift_up !== 1'b0) begin
            errors++; $display("FAIL bp_stall%0d got v%b %h l%b s%b exp v1 %h l%b s0", i, stream_valid,
                               stream_data, stream_last, mreg_shift_up, held_d, held_l);
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 stream_ready = 1'((i % 2) == 0);
         @(negedge clk);
         if (!stream_ready) begin
            checks++;
            if (mreg_shift_up !== 1'b0) begin errors++; $display("FAIL bp_pattern_shift%0d got 1 exp 0", i); end
         end
      end
      stream_ready = 1'b1;
      wait_done(1'b0, ok);
      checks++;
      if (!ok || got_q.size() - bq !== N || n_shift - bs !== 4) begin
         errors++; $display("FAIL bp_end got ok %b beats %0d shifts %0d exp 1 4 4", ok, got_q.size() - bq, n_shift - bs);
      end
      for (int k = 0; k < N; k++) begin
         checks++;
         if (bq + k >= got_q.size()) begin
            errors++; $display("FAIL bp_beat%0d got missing exp %h", k, exp_beat(k, 0));
         end else if (got_q[bq+k] !== exp_beat(k, 0) || got_l[bq+k] !== 1'(k == N - 1)) begin
            errors++; $display("FAIL bp_beat%0d got %h l%b exp %h l%b", k, got_q[bq+k], got_l[bq+k],
                               exp_beat(k, 0), 1'(k == N - 1));
         end
      end
   endtask

   task automatic test_clear();
      int bs, bd, bq;
      bit ok;
      load_std();
      stream_ready = 1'b1;
      bs = n_shift; bd = n_done; bq = got_q.size();
      do_start(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (got_q.size() - bq >= 2) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL clr_two_beats got timeout exp 2 beats"); end
      @(posedge clk); #1 clear = 1'b1;
      @(negedge clk);
      checks++;
      if (mreg_shift_up !== 1'b0) begin errors++; $display("FAIL clr_shift_forced got 1 exp 0"); end
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      checks++;
      if (stream_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL clr_idle got valid %b busy %b exp 0 0", stream_valid, busy);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (n_done - bd !== 0 || n_shift - bs !== 3) begin
         errors++; $display("FAIL clr_counts got dones %0d shifts %0d exp 0 3", n_done - bd, n_shift - bs);
      end
      for (int i = 0; i < N; i++) src[i] = m[i];
      bq = got_q.size();
      do_start(1'b0);
      wait_done(1'b0, ok);
      checks++;
      if (!ok || got_q.size() - bq !== N) begin
         errors++; $display("FAIL clr_restart got ok %b beats %0d exp 1 4", ok, got_q.size() - bq);
      end
      for (int k = 0; k < N; k++) begin
         checks++;
         if (bq + k >= got_q.size()) begin
            errors++; $display("FAIL clr_beat%0d got missing exp %h", k, exp_beat(k, 0));
         end else if (got_q[bq+k] !== exp_beat(k, 0) || got_l[bq+k] !== 1'(k == N - 1)) begin
            errors++; $display("FAIL clr_beat%0d got %h l%b exp %h l%b", k, got_q[bq+k], got_l[bq+k],
                               exp_beat(k, 0), 1'(k == N - 1));
         end
      end
   endtask

   task automatic test_start_ignored();
      int bd, bq, bs;
      bit ok;
      load_std();
      stream_ready = 1'b1;
      bd = n_done; bq = got_q.size();
      do_start(1'b0);
      @(posedge clk); #1 start = 1'b1; start_transpose = 1'b1;
      @(posedge clk); #1 start = 1'b0; start_transpose = 1'b0;
      wait_done(1'b0, ok);
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (!ok || n_done - bd !== 1 || got_q.size() - bq !== N || busy !== 1'b0) begin
         errors++; $display("FAIL ign_counts got ok %b dones %0d beats %0d busy %b exp 1 1 4 0",
                            ok, n_done - bd, got_q.size() - bq, busy);
      end
      for (int k = 0; k < N; k++) begin
         checks++;
         if (bq + k < got_q.size() && got_q[bq+k] !== exp_beat(k, 0)) begin
            errors++; $display("FAIL ign_beat%0d got %h exp %h", k, got_q[bq+k], exp_beat(k, 0));
         end
      end
      bs = n_shift;
      @(posedge clk); #1 start = 1'b1; clear = 1'b1;
      @(posedge clk); #1 start = 1'b0; clear = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_clear_busy got %b exp 0", busy); end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (n_shift - bs !== 0 || busy !== 1'b0) begin
         errors++; $display("FAIL start_clear_quiet got shifts %0d busy %b exp 0 0", n_shift - bs, busy);
      end
   endtask

   task automatic test_async_reset();
      int bs, bq;
      bit ok;
      load_std();
      stream_ready = 1'b1;
      do_start(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (stream_valid === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok || mreg_shift_up !== 1'b1) begin
         errors++; $display("FAIL arst_precond got valid_seen %b shift %b exp 1 1", ok, mreg_shift_up);
      end
      #2 rstnn = 1'b0;
      #1;
      checks++;
      if (stream_valid !== 1'b0 || busy !== 1'b0 || mreg_shift_up !== 1'b0) begin
         errors++; $display("FAIL arst_immediate got valid %b busy %b shift %b exp 0 0 0",
                            stream_valid, busy, mreg_shift_up);
      end
      bs = n_shift;
      repeat (2) @(negedge clk);
      #1 rstnn = 1'b1;
      checks++;
      if (n_shift - bs !== 0 || mreg_transpose !== 1'b0) begin
         errors++; $display("FAIL arst_quiet got shifts %0d xpose %b exp 0 0", n_shift - bs, mreg_transpose);
      end
      load_std();
      bq = got_q.size();
      do_start(1'b0);
      wait_done(1'b0, ok);
      checks++;
      if (!ok || got_q.size() - bq !== N) begin
         errors++; $display("FAIL arst_after got ok %b beats %0d exp 1 4", ok, got_q.size() - bq);
      end
      for (int k = 0; k < N; k++) begin
         checks++;
         if (bq + k < got_q.size() && got_q[bq+k] !== exp_beat(k, 0)) begin
            errors++; $display("FAIL arst_beat%0d got %h exp %h", k, got_q[bq+k], exp_beat(k, 0));
         end
      end
   endtask

   task automatic test_random();
      int bs, bq, bx;
      bit ok, xp;
      for (int it = 0; it < 12; it++) begin
         load_matrix($urandom, $urandom, $urandom, $urandom);
         xp = 1'($urandom_range(0, 1));
         stream_ready = 1'($urandom_range(0, 1));
         bs = n_shift; bq = got_q.size(); bx = n_xpose;
         do_start(xp);
         wait_done(1'b1, ok);
         @(negedge clk); #1;
         checks++;
         if (!ok || got_q.size() - bq !== N || n_shift - bs !== 4 || n_xpose - bx !== int'(xp)) begin
            errors++; $display("FAIL rnd%0d_counts got ok %b beats %0d shifts %0d xposes %0d exp 1 4 4 %0d",
                               it, ok, got_q.size() - bq, n_shift - bs, n_xpose - bx, xp);
         end
         for (int k = 0; k < N; k++) begin
            checks++;
            if (bq + k >= got_q.size()) begin
               errors++; $display("FAIL rnd%0d_beat%0d got missing exp %h", it, k, exp_beat(k, xp));
            end else if (got_q[bq+k] !== exp_beat(k, xp) || got_l[bq+k] !== 1'(k == N - 1)) begin
               errors++; $display("FAIL rnd%0d_beat%0d got %h l%b exp %h l%b", it, k, got_q[bq+k],
                                  got_l[bq+k], exp_beat(k, xp), 1'(k == N - 1));
            end
         end
         checks++;
         if (m[0] !== '0 || m[1] !== '0 || m[2] !== '0 || m[3] !== '0) begin
            errors++; $display("FAIL rnd%0d_mreg_empty got %h %h %h %h exp 0", it, m[0], m[1], m[2], m[3]);
         end
      end
   endtask

   initial begin
      rstnn = 1'b0; start = 1'b0; start_transpose = 1'b0; clear = 1'b0;
      stream_ready = 1'b0; ld_req = 1'b0;
      for (int i = 0; i < N; i++) ld_val[i] = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_plain();
      test_transpose();
      test_backpressure();
      test_clear();
      test_start_ignored();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
